// File: rtl/bp_trace_ctrl.sv
// bp_trace_ctrl
// Sequences the commit-trace stream from bp_trace_encoder into the trace FIFO.
// Each session is framed by start/stop markers. A sync packet carrying the
// current commit PC is emitted at session start and after every
// sync_period_p data packets. The commit pipe is never stalled: an encoder
// packet that cannot be taken is dropped and counted, and the count is
// reported later in a single overflow packet.
//
// Packet layout: [W-1:W-2] = type, [W-3:0] = payload.
//   00 data     payload = enc_data_i[W-3:0]
//   01 sync     payload = zero-extended sync_pc_i
//   10 overflow payload = zero-extended drop count
//   11 marker   payload 0 = start, 1 = stop

module bp_trace_ctrl #(
  parameter int unsigned trace_width_p    = 64,
  parameter int unsigned vaddr_width_p    = 39,
  parameter int unsigned sync_period_p    = 256,
  parameter int unsigned drop_cnt_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic [vaddr_width_p-1:0]    sync_pc_i,
  input  logic [trace_width_p-1:0]    enc_data_i,
  input  logic                        enc_v_i,
  output logic [trace_width_p-1:0]    trace_data_o,
  output logic                        trace_v_o,
  input  logic                        trace_ready_i,
  output logic [drop_cnt_width_p-1:0] drop_count_o,
  output logic                        busy_o
);

  localparam int unsigned payload_w_lp = trace_width_p - 2;
  localparam int unsigned pkt_cnt_w_lp = (sync_period_p > 2) ? $clog2(sync_period_p) : 1;

  localparam logic [1:0] type_data_lp   = 2'b00;
  localparam logic [1:0] type_sync_lp   = 2'b01;
  localparam logic [1:0] type_ovf_lp    = 2'b10;
  localparam logic [1:0] type_marker_lp = 2'b11;

  localparam logic [pkt_cnt_w_lp-1:0] pkt_cnt_last_lp = pkt_cnt_w_lp'(sync_period_p - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    STOP
  } state_e;

  state_e                      state_q,     state_d;
  logic                        valid_q,     valid_d;
  logic [trace_width_p-1:0]    data_q,      data_d;
  logic [drop_cnt_width_p-1:0] drop_cnt_q,  drop_cnt_d;
  logic [pkt_cnt_w_lp-1:0]     pkt_cnt_q,   pkt_cnt_d;
  logic                        sync_pend_q, sync_pend_d;
  logic                        ovf_pend_q,  ovf_pend_d;
  logic                        busy_q,      busy_d;

  // Output slot can take a new packet this cycle.
  logic slot_free;
  assign slot_free = ~valid_q | trace_ready_i;

  // Candidate packets, built once and selected by the FSM.
  logic [trace_width_p-1:0]    data_pkt, sync_pkt, ovf_pkt, start_pkt, stop_pkt;
  logic [drop_cnt_width_p-1:0] drop_cnt_inc;

  assign data_pkt     = {type_data_lp,   enc_data_i[payload_w_lp-1:0]};
  assign sync_pkt     = {type_sync_lp,   payload_w_lp'(sync_pc_i)};
  assign ovf_pkt      = {type_ovf_lp,    payload_w_lp'(drop_cnt_q)};
  assign start_pkt    = {type_marker_lp, payload_w_lp'(0)};
  assign stop_pkt     = {type_marker_lp, payload_w_lp'(1)};
  assign drop_cnt_inc = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + drop_cnt_width_p'(1);

  // The type field of the encoder word is replaced, never forwarded.
  logic [1:0] unused_enc_type;
  assign unused_enc_type = enc_data_i[trace_width_p-1 -: 2];

  // State and output slot registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      data_q      <= '0;
      drop_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      sync_pend_q <= 1'b0;
      ovf_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      drop_cnt_q  <= drop_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      sync_pend_q <= sync_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: packet selection, drop accounting and sync scheduling.
  logic                     load;
  logic                     data_load;
  logic                     ovf_load;
  logic                     drop;
  logic [trace_width_p-1:0] pkt;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q & ~trace_ready_i;
    data_d      = data_q;
    drop_cnt_d  = drop_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    sync_pend_d = sync_pend_q;
    ovf_pend_d  = ovf_pend_q;
    busy_d      = busy_q;
    load        = 1'b0;
    data_load   = 1'b0;
    ovf_load    = 1'b0;
    drop        = 1'b0;
    pkt         = '0;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d    = START;
          drop_cnt_d = '0;
          ovf_pend_d = 1'b0;
        end
      end

      START: begin
        if (slot_free) begin
          load        = 1'b1;
          pkt         = start_pkt;
          state_d     = RUN;
          sync_pend_d = 1'b1;
          pkt_cnt_d   = '0;
        end
      end

      RUN: begin
        if (!enable_i) begin
          state_d = STOP;
        end else begin
          if (slot_free) begin
            if (ovf_pend_q) begin
              load     = 1'b1;
              ovf_load = 1'b1;
              pkt      = ovf_pkt;
            end else if (sync_pend_q) begin
              load        = 1'b1;
              pkt         = sync_pkt;
              sync_pend_d = 1'b0;
            end else if (enc_v_i) begin
              load      = 1'b1;
              data_load = 1'b1;
              pkt       = data_pkt;
            end
          end
          drop = enc_v_i & ~data_load;
        end
      end

      STOP: begin
        if (slot_free) begin
          load = 1'b1;
          if (ovf_pend_q) begin
            ovf_load = 1'b1;
            pkt      = ovf_pkt;
          end else begin
            pkt     = stop_pkt;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Every sync_period_p-th data packet schedules a sync.
    if (data_load) begin
      if (pkt_cnt_q == pkt_cnt_last_lp) begin
        pkt_cnt_d   = '0;
        sync_pend_d = 1'b1;
      end else begin
        pkt_cnt_d = pkt_cnt_q + pkt_cnt_w_lp'(1);
      end
    end

    // An overflow report restarts the count, keeping a drop from this same cycle.
    if (ovf_load) begin
      drop_cnt_d = drop ? drop_cnt_width_p'(1) : '0;
      ovf_pend_d = drop;
    end else if (drop) begin
      drop_cnt_d = drop_cnt_inc;
      ovf_pend_d = 1'b1;
    end

    if (load) begin
      valid_d = 1'b1;
      data_d  = pkt;
    end

    busy_d = (state_d != IDLE) | valid_d;
  end

  assign trace_data_o = data_q;
  assign trace_v_o    = valid_q;
  assign drop_count_o = drop_cnt_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_bp_trace_ctrl.sv
// Bench for bp_trace_ctrl: randomized and directed stimulus, a transaction-level
// reference model feeding an expected-packet queue, and a monitor that pops
// and compares whenever the FIFO side accepts a packet.

module tb_bp_trace_ctrl;

  localparam int unsigned W  = 64;
  localparam int unsigned VA = 39;
  localparam int unsigned P  = 4;
  localparam int unsigned DW = 4;
  localparam int          MAXD = (1 << DW) - 1;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          enable   = 1'b0;
  logic          enc_v    = 1'b0;
  logic          ready    = 1'b1;
  logic [VA-1:0] pc       = '0;
  logic [W-1:0]  enc_data = '0;
  logic [W-1:0]  trace_data;
  logic          trace_v;
  logic          busy;
  logic [DW-1:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state: session flags, owed control packets, unbounded drop tally.
  bit m_active, m_start_owed, m_stopping, m_sync_owed, m_ovf_owed, m_valid;
  int m_since_sync, m_drops;

  bit           prev_hold;
  logic [W-1:0] prev_data;

  always #5 clk = ~clk;

  bp_trace_ctrl #(
    .trace_width_p   (W),
    .vaddr_width_p   (VA),
    .sync_period_p   (P),
    .drop_cnt_width_p(DW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .enable_i     (enable),
    .sync_pc_i    (pc),
    .enc_data_i   (enc_data),
    .enc_v_i      (enc_v),
    .trace_data_o (trace_data),
    .trace_v_o    (trace_v),
    .trace_ready_i(ready),
    .drop_count_o (drop_count),
    .busy_o       (busy)
  );

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] mk(input logic [1:0] t, input logic [W-3:0] p);
    return {t, p};
  endfunction

  // Drop count as the hardware reports it: saturates at all-ones.
  function automatic int reported();
    return (m_drops > MAXD) ? MAXD : m_drops;
  endfunction

  function automatic void emit(input logic [W-1:0] p);
    exp_q.push_back(p);
    m_valid = 1'b1;
  endfunction

  // Reference model: decides, per clock, which packet (if any) enters the slot.
  always @(posedge clk) begin : ref_model
    bit free, took;
    if (rst) begin
      m_active = 0; m_start_owed = 0; m_stopping = 0; m_sync_owed = 0;
      m_ovf_owed = 0; m_valid = 0; m_since_sync = 0; m_drops = 0;
      exp_q.delete();
    end else begin
      free = !m_valid || ready;
      if (ready) m_valid = 1'b0;
      took = 1'b0;
      if (!m_active) begin
        if (enable) begin
          m_active = 1; m_start_owed = 1; m_drops = 0; m_ovf_owed = 0;
        end
      end else if (m_start_owed) begin
        if (free) begin
          emit(mk(2'b11, (W-2)'(0)));
          m_start_owed = 0; m_sync_owed = 1; m_since_sync = 0;
        end
      end else if (!m_stopping) begin
        if (!enable) begin
          m_stopping = 1;
        end else begin
          if (free && m_ovf_owed) begin
            emit(mk(2'b10, (W-2)'(reported())));
            m_drops = 0; m_ovf_owed = 0;
          end else if (free && m_sync_owed) begin
            emit(mk(2'b01, (W-2)'(pc)));
            m_sync_owed = 0;
          end else if (free && enc_v) begin
            emit(mk(2'b00, enc_data[W-3:0]));
            took = 1;
            m_since_sync++;
            if (m_since_sync == P) begin
              m_sync_owed = 1; m_since_sync = 0;
            end
          end
          if (enc_v && !took) begin
            m_drops++; m_ovf_owed = 1;
          end
        end
      end else if (free) begin
        if (m_ovf_owed) begin
          emit(mk(2'b10, (W-2)'(reported())));
          m_drops = 0; m_ovf_owed = 0;
        end else begin
          emit(mk(2'b11, (W-2)'(1)));
          m_active = 0; m_stopping = 0;
        end
      end
    end
  end

  // Monitor: mid-cycle checks of slot state, hold stability and accepted packets.
  always @(negedge clk) begin : monitor
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk("valid", W'(trace_v), W'(m_valid));
      chk("drop_count", W'(drop_count), W'(reported()));
      chk("busy", W'(busy), W'(m_active || m_valid));
      if (prev_hold && trace_v) chk("hold", trace_data, prev_data);
      if (trace_v && ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pkt: DUT sent %h, expected no packet at t=%0t", trace_data, $time);
        end else begin
          chk("pkt", trace_data, exp_q.pop_front());
        end
      end
      prev_hold = trace_v && !ready;
      prev_data = trace_data;
    end
  end

  // Apply one input set for n clock edges; returns 2 time units after the last edge.
  task automatic cyc(input bit en, input bit v, input bit rdy, input int n);
    repeat (n) begin
      enable   = en;
      enc_v    = v;
      ready    = rdy;
      enc_data = {$urandom, $urandom};
      pc       = VA'({$urandom, $urandom});
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : stim
    cyc(0, 0, 1, 2);
    chk("rst_valid", W'(trace_v), W'(0));
    chk("rst_data", trace_data, W'(0));
    chk("rst_drops", W'(drop_count), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    rst = 1'b0;

    // Session start: start marker, then sync with the sampled PC, then data.
    cyc(1, 0, 1, 2);
    chk("start_marker", trace_data, mk(2'b11, (W-2)'(0)));
    cyc(1, 0, 1, 1);
    chk("first_sync", trace_data, mk(2'b01, (W-2)'(pc)));
    cyc(1, 1, 1, 4);
    cyc(1, 0, 1, 3);

    // Sync insertion with sparse encoder traffic.
    for (int i = 0; i < 30; i++) cyc(1, $urandom_range(1, 0) == 1, 1, 1);
    cyc(1, 0, 1, 4);

    // Stall: first packet held, the next four dropped, then one overflow.
    cyc(1, 1, 0, 5);
    chk("stall_drops", W'(drop_count), W'(4));
    chk("stall_valid", W'(trace_v), W'(1));
    cyc(1, 0, 1, 1);
    chk("ovf_loaded", trace_data, mk(2'b10, (W-2)'(4)));
    chk("ovf_cleared", W'(drop_count), W'(0));
    cyc(1, 0, 1, 4);

    // Saturation of the drop counter.
    cyc(1, 1, 0, 20);
    chk("sat_drops", W'(drop_count), W'(MAXD));
    cyc(1, 0, 1, 1);
    chk("sat_ovf", trace_data, mk(2'b10, (W-2)'(MAXD)));
    cyc(1, 0, 1, 4);

    // Disable with an overflow pending: overflow, stop marker, idle.
    cyc(1, 1, 0, 3);
    cyc(0, 0, 1, 2);
    chk("stop_ovf", trace_data, mk(2'b10, (W-2)'(2)));
    cyc(0, 0, 1, 1);
    chk("stop_marker", trace_data, mk(2'b11, (W-2)'(1)));
    cyc(0, 0, 1, 1);
    chk("idle_busy", W'(busy), W'(0));
    cyc(0, 1, 1, 4);
    chk("idle_drops", W'(drop_count), W'(0));
    chk("idle_valid", W'(trace_v), W'(0));

    // Randomized traffic, back-pressure and session toggling.
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(15, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0, 1);

    // Reset in the middle of a stall.
    cyc(1, 0, 1, 6);
    cyc(1, 1, 0, 3);
    chk("pre_rst_valid", W'(trace_v), W'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", W'(trace_v), W'(0));
    chk("async_rst_drops", W'(drop_count), W'(0));
    chk("async_rst_busy", W'(busy), W'(0));
    cyc(1, 1, 0, 2);
    rst = 1'b0;

    cyc(1, 1, 1, 20);
    cyc(0, 0, 1, 12);
    chk("drained", W'(exp_q.size()), W'(0));
    chk("end_busy", W'(busy), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time budget exceeded, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
